instr_fetch_unit: RTL

//  Fetch stage upstream of the byte-addressable instruction memory. Owns the PC and drives the
//  11-bit word-aligned fetch address. Captures the combinationally-read 32-bit instruction into
//  a one-entry fetch register, then hands {instr, pc} to decode over a valid/ready handshake.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/instr_fetch_unit_if.sv | 50 +++++
 rtl/instr_fetch_unit_perf_cnt.sv | 35 +++
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared types and constants for the fetch stage.
//   fetch_state_e : BOOT / RUN / TRAP fetch controller states
//   trap_cause_e  : encoding driven on trap_cause (00 none, 01 misaligned, 10 out of range)
//   INSTR_BYTES   : PC increment per sequential fetch
package cpu_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    TC_NONE     = 2'b00,
    TC_MISALIGN = 2'b01,
    TC_RANGE    = 2'b10
  } trap_cause_e;

  // Instructions are 4-byte aligned; any set bit in the low two address bits is a fault.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if -- bundles the instruction-memory port, the redirect input,
// the decode handshake and the trap status of the fetch stage.
//   imem_addr/imem_data           : combinational instruction memory read
//   redirect_valid/redirect_pc    : taken branch/jump target
//   out_valid/out_ready           : decode handshake, payload out_instr/out_pc
//   trap/trap_cause               : sticky fetch fault and its cause
// Modports: master = fetch unit, slave = memory/decode side.
interface instr_fetch_unit_if #(
  parameter int PC_W   = 32,
  parameter int ADDR_W = 11
) ();

  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [PC_W-1:0]   out_pc;
  logic              trap;
  logic [1:0]        trap_cause;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output trap,
    output trap_cause
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  trap,
    input  trap_cause
  );

endinterface

// File: rtl/instr_fetch_unit_perf_cnt.sv
// fetch_perf_cnt -- two saturating 32-bit event counters for the fetch stage.
//   clk, rst_n        : clock, async active-low reset
//   fetch_inc_i       : one instruction captured this cycle
//   stall_inc_i       : fetch register held by decode back-pressure this cycle
//   freeze_i          : counters hold their value (fetch trapped)
//   perf_fetch_cnt_o  : captured instruction count
//   perf_stall_cnt_o  : stall cycle count
// Only instantiated when FETCH_PERF_CNT_EN is defined.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_inc_i,
  input  logic        stall_inc_i,
  input  logic        freeze_i,
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_stall_cnt_o
);

  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (!freeze_i) begin
      if (fetch_inc_i && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_inc_i && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit -- fetch stage: owns the PC, reads the instruction memory,
// holds one fetched instruction for decode and traps on bad fetch targets.
//   clk, rst_n          : clock, async active-low reset
//   fif (master)        : imem port, redirect input, decode handshake, trap status
//   perf_fetch_cnt[31:0]: captures so far      (only with FETCH_PERF_CNT_EN)
//   perf_stall_cnt[31:0]: back-pressure cycles (only with FETCH_PERF_CNT_EN)
// Optional feature macro: FETCH_PERF_CNT_EN.
//
// state | meaning
// ------+-----------------------------------------------------------------
// BOOT  | first cycle after reset release, no fetch (one bubble)
// RUN   | fetching; capture when the fetch register is empty or drained
// TRAP  | fetch fault seen; everything frozen until reset
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              ADDR_W   = 11,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master fif
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  fetch_state_e      state_q;
  trap_cause_e       cause_q;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   pc_d;
  logic              valid_q;
  logic [31:0]       instr_q;
  logic [PC_W-1:0]   opc_q;
  logic              trap_q;

  logic              misalign;
  logic              range_fault;
  logic              load;
  logic              capture;

  assign pc_d        = pc_q + PC_W'(INSTR_BYTES);
  assign misalign    = fif.redirect_valid && is_misaligned(fif.redirect_pc[1:0]);
  // Any PC bit above the memory window means the fetch would alias; fault instead.
  assign range_fault = |pc_q[PC_W-1:ADDR_W];
  assign load        = !valid_q || fif.out_ready;
  assign capture     = (state_q == RUN) && !fif.redirect_valid && !range_fault && load;

  // In RUN with no redirect and no fault, out_ready=1 always implies a load, so the
  // "accepted without a new capture" case only arises on redirect/fault cycles, which
  // already clear valid_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      cause_q <= TC_NONE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      opc_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (misalign) begin
            state_q <= TRAP;
            trap_q  <= 1'b1;
            cause_q <= TC_MISALIGN;
            pc_q    <= fif.redirect_pc;
            valid_q <= 1'b0;
          end else if (range_fault) begin
            state_q <= TRAP;
            trap_q  <= 1'b1;
            cause_q <= TC_RANGE;
            valid_q <= 1'b0;
          end else if (fif.redirect_valid) begin
            pc_q    <= fif.redirect_pc;
            valid_q <= 1'b0;
          end else if (load) begin
            instr_q <= fif.imem_data;
            opc_q   <= pc_q;
            valid_q <= 1'b1;
            pc_q    <= pc_d;
          end
        end
        TRAP: valid_q <= 1'b0;
        default: state_q <= TRAP;
      endcase
    end
  end

  assign fif.imem_addr  = pc_q[ADDR_W-1:0];
  assign fif.out_valid  = valid_q;
  assign fif.out_instr  = instr_q;
  assign fif.out_pc     = opc_q;
  assign fif.trap       = trap_q;
  assign fif.trap_cause = cause_q;

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_inc_i      (capture),
    .stall_inc_i      (valid_q && !fif.out_ready),
    .freeze_i         (state_q == TRAP),
    .perf_fetch_cnt_o (perf_fetch_cnt),
    .perf_stall_cnt_o (perf_stall_cnt)
  );
`endif

endmodule
